// File: rtl/msix_sched_pkg.sv
// Shared types and constants for the MSI-X vector scheduler.
package msix_sched_pkg;

    localparam int MSIX_MAX_VECTORS = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        SEND  = 3'd4
    } sched_state_e;

    typedef struct packed {
        logic [31:0] addr_lo;
        logic [31:0] addr_hi;
        logic [31:0] data;
        logic        mask;
    } msix_entry_t;

endpackage

// File: rtl/msix_rr_arbiter.sv
// Round-robin find-first-set: returns the first set request at or after
// ptr, wrapping from NUM_VECTORS-1 back to 0. Purely combinational.
module msix_rr_arbiter #(
    parameter int NUM_VECTORS = 8,
    localparam int VEC_W = $clog2(NUM_VECTORS)
)(
    input  logic [NUM_VECTORS-1:0] req,
    input  logic [VEC_W-1:0]       ptr,
    output logic [VEC_W-1:0]       grant,
    output logic                   found
);

    localparam int SW = VEC_W + 1;

    logic [SW-1:0] sum_s;

    // Scan from the pointer upwards, taking the first pending request
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum_s = '0;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            sum_s = {1'b0, ptr} + SW'(i);
            if (sum_s >= SW'(NUM_VECTORS)) begin
                sum_s = sum_s - SW'(NUM_VECTORS);
            end else begin
                sum_s = sum_s;
            end
            if (!found && req[sum_s[VEC_W-1:0]]) begin
                found = 1'b1;
                grant = sum_s[VEC_W-1:0];
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/msi_x_vector_scheduler.sv
// MSI-X vector scheduler: pending bit array, round-robin pick, table fetch
// and one memory-write message request per serviced vector.
// Optional feature macro: MSIX_SCHED_STATS_EN adds saturating message and
// masked-exit counters (stat_msg_cnt, stat_mask_cnt).
module msi_x_vector_scheduler
    import msix_sched_pkg::*;
#(
    parameter int NUM_VECTORS = 8,
    localparam int VEC_W = $clog2(NUM_VECTORS)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   msix_enable,
    input  logic                   function_mask,
    input  logic [NUM_VECTORS-1:0] vec_event,
    output logic                   tbl_rd_req,
    output logic [VEC_W-1:0]       tbl_rd_idx,
    input  logic                   tbl_rd_valid,
    input  logic [31:0]            tbl_addr_lo,
    input  logic [31:0]            tbl_addr_hi,
    input  logic [31:0]            tbl_data,
    input  logic                   tbl_vec_mask,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic [63:0]            msg_addr,
    output logic [31:0]            msg_data,
    output logic                   msg_is_64bit,
    output logic [VEC_W-1:0]       msg_vec,
    output logic [NUM_VECTORS-1:0] pba
`ifdef MSIX_SCHED_STATS_EN
    ,
    output logic [15:0]            stat_msg_cnt,
    output logic [15:0]            stat_mask_cnt
`endif
);

    sched_state_e           state_r;
    sched_state_e           state_s;
    logic [VEC_W-1:0]       rr_ptr_r;
    logic [VEC_W-1:0]       winner_r;
    logic [VEC_W-1:0]       winner_inc_s;
    logic [VEC_W-1:0]       arb_idx_s;
    logic                   arb_found_s;
    msix_entry_t            entry_r;
    logic                   is64_r;
    logic                   hs_s;
    logic                   mask_exit_s;
    logic [NUM_VECTORS-1:0] clr_s;

    msix_rr_arbiter #(.NUM_VECTORS(NUM_VECTORS)) u_arb (
        .req   (pba),
        .ptr   (rr_ptr_r),
        .grant (arb_idx_s),
        .found (arb_found_s)
    );

    assign winner_inc_s = (winner_r == VEC_W'(NUM_VECTORS - 1)) ? '0 : winner_r + VEC_W'(1);
    assign hs_s         = msg_valid & msg_ready & msix_enable;
    assign mask_exit_s  = msix_enable & (state_r == CHECK) & (entry_r.mask | function_mask);

    assign tbl_rd_idx   = winner_r;
    assign msg_vec      = winner_r;
    assign msg_addr     = {entry_r.addr_hi, entry_r.addr_lo & 32'hFFFF_FFFC};
    assign msg_data     = entry_r.data;
    assign msg_is_64bit = is64_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; losing MSI-X Enable aborts everything back to IDLE
    always_comb begin
        state_s = state_r;
        if (!msix_enable) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_s = (!function_mask && arb_found_s) ? FETCH : IDLE;
                FETCH:   state_s = WAIT;
                WAIT:    state_s = tbl_rd_valid ? CHECK : WAIT;
                CHECK:   state_s = (entry_r.mask || function_mask) ? IDLE : SEND;
                SEND:    state_s = msg_ready ? IDLE : SEND;
                default: state_s = IDLE;
            endcase
        end
    end

    // Registered strobes aligned with the FETCH and SEND states
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_rd_req <= 1'b0;
            msg_valid  <= 1'b0;
        end else begin
            tbl_rd_req <= (state_s == FETCH);
            msg_valid  <= (state_s == SEND);
        end
    end

    // Winner latch, table entry capture and round-robin pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner_r <= '0;
            rr_ptr_r <= '0;
            entry_r  <= '0;
            is64_r   <= 1'b0;
        end else begin
            if (state_r == IDLE && state_s == FETCH) begin
                winner_r <= arb_idx_s;
            end else begin
                winner_r <= winner_r;
            end
            if (msix_enable && state_r == WAIT && tbl_rd_valid) begin
                entry_r <= '{addr_lo: tbl_addr_lo, addr_hi: tbl_addr_hi,
                             data: tbl_data, mask: tbl_vec_mask};
                is64_r  <= |tbl_addr_hi;
            end else begin
                entry_r <= entry_r;
                is64_r  <= is64_r;
            end
            if (hs_s || mask_exit_s) begin
                rr_ptr_r <= winner_inc_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Clear mask for the serviced vector on handshake
    always_comb begin
        clr_s = '0;
        if (hs_s) begin
            clr_s[winner_r] = 1'b1;
        end else begin
            clr_s = '0;
        end
    end

    // Pending bits: a new event in the handshake cycle beats the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pba <= '0;
        end else if (!msix_enable) begin
            pba <= '0;
        end else begin
            pba <= (pba & ~clr_s) | vec_event;
        end
    end

`ifdef MSIX_SCHED_STATS_EN
    // Saturating counters of sent messages and masked CHECK exits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_msg_cnt  <= 16'd0;
            stat_mask_cnt <= 16'd0;
        end else begin
            if (hs_s && stat_msg_cnt != 16'hFFFF) begin
                stat_msg_cnt <= stat_msg_cnt + 16'd1;
            end else begin
                stat_msg_cnt <= stat_msg_cnt;
            end
            if (mask_exit_s && stat_mask_cnt != 16'hFFFF) begin
                stat_mask_cnt <= stat_mask_cnt + 16'd1;
            end else begin
                stat_mask_cnt <= stat_mask_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_msi_x_vector_scheduler.sv
// Directed self-checking bench for msi_x_vector_scheduler (NUM_VECTORS=8).
// Builds with or without MSIX_SCHED_STATS_EN.
module tb_msi_x_vector_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        msix_enable;
    logic        function_mask;
    logic [7:0]  vec_event;
    logic        tbl_rd_req;
    logic [2:0]  tbl_rd_idx;
    logic        tbl_rd_valid;
    logic [31:0] tbl_addr_lo;
    logic [31:0] tbl_addr_hi;
    logic [31:0] tbl_data;
    logic        tbl_vec_mask;
    logic        msg_valid;
    logic        msg_ready;
    logic [63:0] msg_addr;
    logic [31:0] msg_data;
    logic        msg_is_64bit;
    logic [2:0]  msg_vec;
    logic [7:0]  pba;
`ifdef MSIX_SCHED_STATS_EN
    logic [15:0] stat_msg_cnt;
    logic [15:0] stat_mask_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // MSI-X table contents served by the responder below
    logic [31:0] tbl_lo  [8];
    logic [31:0] tbl_hi  [8];
    logic [31:0] tbl_dat [8];
    logic        tbl_msk [8];
    logic        rd_pend = 1'b0;
    logic [2:0]  idx_q = 3'd0;

    always #5 clk = ~clk;

    // Table responder: read data valid one cycle after the strobe
    always @(posedge clk) begin
        rd_pend <= tbl_rd_req;
        idx_q   <= tbl_rd_idx;
    end

    assign tbl_rd_valid = rd_pend;
    assign tbl_addr_lo  = tbl_lo[idx_q];
    assign tbl_addr_hi  = tbl_hi[idx_q];
    assign tbl_data     = tbl_dat[idx_q];
    assign tbl_vec_mask = tbl_msk[idx_q];

    msi_x_vector_scheduler #(.NUM_VECTORS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .msix_enable   (msix_enable),
        .function_mask (function_mask),
        .vec_event     (vec_event),
        .tbl_rd_req    (tbl_rd_req),
        .tbl_rd_idx    (tbl_rd_idx),
        .tbl_rd_valid  (tbl_rd_valid),
        .tbl_addr_lo   (tbl_addr_lo),
        .tbl_addr_hi   (tbl_addr_hi),
        .tbl_data      (tbl_data),
        .tbl_vec_mask  (tbl_vec_mask),
        .msg_valid     (msg_valid),
        .msg_ready     (msg_ready),
        .msg_addr      (msg_addr),
        .msg_data      (msg_data),
        .msg_is_64bit  (msg_is_64bit),
        .msg_vec       (msg_vec),
        .pba           (pba)
`ifdef MSIX_SCHED_STATS_EN
        ,
        .stat_msg_cnt  (stat_msg_cnt),
        .stat_mask_cnt (stat_mask_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance until msg_valid (bounded), then check every message field
    task automatic wait_msg(input string tag, input logic [2:0] vec, input logic [63:0] addr,
                            input logic [31:0] data, input logic is64);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (msg_valid !== 1'b1 && n < 40);
        chk({tag, " valid"}, {63'd0, msg_valid}, 64'd1);
        chk({tag, " vec"},   {61'd0, msg_vec}, {61'd0, vec});
        chk({tag, " addr"},  msg_addr, addr);
        chk({tag, " data"},  {32'd0, msg_data}, {32'd0, data});
        chk({tag, " is64"},  {63'd0, msg_is_64bit}, {63'd0, is64});
    endtask

    initial begin
        int reads;
        logic saw;

        for (int i = 0; i < 8; i++) begin
            tbl_lo[i]  = 32'hFEE0_0000 | (32'(i) << 4);
            tbl_hi[i]  = 32'd0;
            tbl_dat[i] = 32'h100 + 32'(i);
            tbl_msk[i] = 1'b0;
        end
        tbl_lo[3]  = 32'hFEE0_0004;
        tbl_dat[3] = 32'h41;
        tbl_lo[4]  = 32'h8000_0003;
        tbl_hi[4]  = 32'h1;

        rst = 1'b1; msix_enable = 1'b0; function_mask = 1'b0;
        vec_event = 8'h00; msg_ready = 1'b0;
        step(); step();
        chk("rst pba",       {56'd0, pba}, 64'd0);
        chk("rst rd_req",    {63'd0, tbl_rd_req}, 64'd0);
        chk("rst msg_valid", {63'd0, msg_valid}, 64'd0);
        chk("rst msg_addr",  msg_addr, 64'd0);
        chk("rst msg_vec",   {61'd0, msg_vec}, 64'd0);
        rst = 1'b0; msix_enable = 1'b1; msg_ready = 1'b1;
        step();

        // 1: single 32-bit message on vector 3
        vec_event = 8'h08; step(); vec_event = 8'h00;
        chk("t1 pba set", {56'd0, pba}, 64'h08);
        wait_msg("t1", 3'd3, 64'h0000_0000_FEE0_0004, 32'h41, 1'b0);
        step();
        chk("t1 pba clr", {56'd0, pba}, 64'h00);
        chk("t1 valid drop", {63'd0, msg_valid}, 64'd0);

        // 2: 64-bit address with low bits forced to zero (pointer now 4)
        vec_event = 8'h10; step(); vec_event = 8'h00;
        wait_msg("t2", 3'd4, 64'h0000_0001_8000_0000, 32'h104, 1'b1);

        // 3: move pointer to 6, then 1/5/7 together -> 7, 1, 5
        vec_event = 8'h20; step(); vec_event = 8'h00;
        wait_msg("t3 pre", 3'd5, 64'h0000_0000_FEE0_0050, 32'h105, 1'b0);
        step();
        vec_event = 8'hA2; step(); vec_event = 8'h00;
        wait_msg("t3 a", 3'd7, 64'h0000_0000_FEE0_0070, 32'h107, 1'b0);
        wait_msg("t3 b", 3'd1, 64'h0000_0000_FEE0_0010, 32'h101, 1'b0);
        wait_msg("t3 c", 3'd5, 64'h0000_0000_FEE0_0050, 32'h105, 1'b0);
        step();
        chk("t3 pba", {56'd0, pba}, 64'h00);

        // 4: masked vector 2 keeps re-arbitrating without sending
        tbl_msk[2] = 1'b1;
        vec_event = 8'h04; step(); vec_event = 8'h00;
        reads = 0; saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tbl_rd_req === 1'b1) reads++;
            if (msg_valid !== 1'b0) saw = 1'b1;
        end
        chk("t4 no msg", {63'd0, saw}, 64'd0);
        chk("t4 pba kept", {56'd0, pba}, 64'h04);
        chk("t4 rearb", {63'd0, (reads >= 3)}, 64'd1);
        tbl_msk[2] = 1'b0;
        wait_msg("t4 unmask", 3'd2, 64'h0000_0000_FEE0_0020, 32'h102, 1'b0);
        step();
        chk("t4 pba clr", {56'd0, pba}, 64'h00);

        // 5a: stall in SEND, raise function_mask, event on winner at handshake
        msg_ready = 1'b0;
        vec_event = 8'h01; step(); vec_event = 8'h00;
        wait_msg("t5a", 3'd0, 64'h0000_0000_FEE0_0000, 32'h100, 1'b0);
        step();
        chk("t5a hold valid", {63'd0, msg_valid}, 64'd1);
        chk("t5a hold data",  {32'd0, msg_data}, 64'h100);
        function_mask = 1'b1;
        step();
        chk("t5a fmask valid", {63'd0, msg_valid}, 64'd1);
        msg_ready = 1'b1; vec_event = 8'h01;
        step();
        msg_ready = 1'b0; vec_event = 8'h00;
        chk("t5a done", {63'd0, msg_valid}, 64'd0);
        chk("t5a set wins", {56'd0, pba}, 64'h01);

        // 5: function mask holds off all fetches, then 1, 2, 3, 0
        vec_event = 8'h0E; step(); vec_event = 8'h00;
        reads = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tbl_rd_req !== 1'b0) reads++;
        end
        chk("t5 no fetch", 64'(reads), 64'd0);
        chk("t5 pba", {56'd0, pba}, 64'h0F);
        function_mask = 1'b0; msg_ready = 1'b1;
        wait_msg("t5 v1", 3'd1, 64'h0000_0000_FEE0_0010, 32'h101, 1'b0);
        wait_msg("t5 v2", 3'd2, 64'h0000_0000_FEE0_0020, 32'h102, 1'b0);
        wait_msg("t5 v3", 3'd3, 64'h0000_0000_FEE0_0004, 32'h41, 1'b0);
        wait_msg("t5 v0", 3'd0, 64'h0000_0000_FEE0_0000, 32'h100, 1'b0);
        step();
        chk("t5 pba clr", {56'd0, pba}, 64'h00);

        // 6: drop MSI-X Enable while a message is stalled in SEND
        msg_ready = 1'b0;
        vec_event = 8'h10; step(); vec_event = 8'h00;
        wait_msg("t6", 3'd4, 64'h0000_0001_8000_0000, 32'h104, 1'b1);
        msix_enable = 1'b0;
        step();
        chk("t6 valid drop", {63'd0, msg_valid}, 64'd0);
        chk("t6 pba clr", {56'd0, pba}, 64'h00);
        vec_event = 8'hFF; step(); vec_event = 8'h00;
        step();
        chk("t6 events ignored", {56'd0, pba}, 64'h00);
`ifdef MSIX_SCHED_STATS_EN
        chk("t6 stat msg", {48'd0, stat_msg_cnt}, 64'd12);
        chk("t6 stat mask nz", {63'd0, (stat_mask_cnt != 16'd0)}, 64'd1);
`endif
        msix_enable = 1'b1; msg_ready = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (msg_valid !== 1'b0 || tbl_rd_req !== 1'b0) saw = 1'b1;
        end
        chk("t6 stays idle", {63'd0, saw}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
